tt_pin_frame_tx: RTL and testbench

//  Host-side transmitter for the byte-wide 4-phase pin protocol that user projects receive on
//  ui_in[7:0] (data) plus one strobe pin. Buffers bytes from an internal valid/ready source,

---
 rtl/tt_pin_frame_tx.sv | 248 ++++++++++++++++++++++++
 tb/tb_tt_pin_frame_tx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_pin_frame_tx.sv
// Host-side byte transmitter: FIFO-buffered bytes are driven onto the pins with a 4-phase req/ack handshake.
// Optional macro FRAME_CHECKSUM_EN appends an XOR checksum byte after each frame's last byte.
module tt_pin_frame_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] pin_data,
  output logic       pin_req,
  input  logic       pin_ack,
  output logic       busy,
  output logic       timeout_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef FRAME_CHECKSUM_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_t;

  state_t                 state_r, state_next_s;
  logic [SYNC_STAGES-1:0] ack_sync_r;
  logic                   ack_s;
  logic [FW-1:0]          mem_r [FIFO_DEPTH];
  logic [FW-1:0]          head_s, fifo_wdata_s;
  logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]          count_r, count_next_s;
  logic                   push_s, pop_s, flush_s;
  logic [TW-1:0]          tcnt_r, tcnt_next_s;
  logic                   req_r, req_next_s;
  logic [7:0]             data_r, data_next_s;
  logic                   err_r, err_next_s;
  logic                   busy_r, busy_next_s;
  logic                   in_ready_r;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum_r;
  logic       csum_pend_r, cur_last_r;
  logic       frame_done_s, csum_load_s;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign fifo_wdata_s = {in_last, in_data};
`else
  logic unused_s;
  assign unused_s     = in_last;
  assign fifo_wdata_s = in_data;
`endif

  assign ack_s       = ack_sync_r[SYNC_STAGES-1];
  assign head_s      = mem_r[rd_ptr_r];
  assign push_s      = in_valid && in_ready_r && !flush_s;
  assign in_ready    = in_ready_r;
  assign pin_data    = data_r;
  assign pin_req     = req_r;
  assign busy        = busy_r;
  assign timeout_err = err_r;

  // Ack synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      ack_sync_r[0] <= pin_ack;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ack_sync_r[i] <= ack_sync_r[i-1];
      end
    end
  end

  // Handshake FSM next-state and registered-output values
  always_comb begin
    state_next_s = state_r;
    req_next_s   = req_r;
    data_next_s  = data_r;
    tcnt_next_s  = tcnt_r;
    err_next_s   = err_r;
    pop_s        = 1'b0;
    flush_s      = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    frame_done_s = 1'b0;
    csum_load_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
`ifdef FRAME_CHECKSUM_EN
        if (ena && csum_pend_r) begin
          csum_load_s  = 1'b1;
          data_next_s  = csum_r;
          state_next_s = SETUP;
        end else
`endif
        if (ena && (count_r != {CW{1'b0}})) begin
          pop_s        = 1'b1;
          data_next_s  = head_s[7:0];
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        req_next_s   = 1'b1;
        tcnt_next_s  = {TW{1'b0}};
        state_next_s = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s) begin
          req_next_s   = 1'b0;
          tcnt_next_s  = {TW{1'b0}};
          state_next_s = REQ_LO;
        end else if (tcnt_r == T_LAST) begin
          req_next_s   = 1'b0;
          err_next_s   = 1'b1;
          flush_s      = 1'b1;
          tcnt_next_s  = {TW{1'b0}};
          state_next_s = IDLE;
        end else begin
          tcnt_next_s  = tcnt_r + TW'(1);
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_next_s = IDLE;
`ifdef FRAME_CHECKSUM_EN
          frame_done_s = cur_last_r;
`endif
        end else if (tcnt_r == T_LAST) begin
          err_next_s   = 1'b1;
          flush_s      = 1'b1;
          tcnt_next_s  = {TW{1'b0}};
          state_next_s = IDLE;
        end else begin
          tcnt_next_s  = tcnt_r + TW'(1);
        end
      end
      default: begin
        req_next_s   = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // FIFO occupancy after this edge; drives in_ready and busy
  always_comb begin
    count_next_s = count_r;
    if (flush_s) begin
      count_next_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1);
        2'b01:   count_next_s = count_r - CW'(1);
        default: count_next_s = count_r;
      endcase
    end
    busy_next_s = (count_next_s != {CW{1'b0}}) || (state_next_s != IDLE);
`ifdef FRAME_CHECKSUM_EN
    busy_next_s = busy_next_s || frame_done_s || (csum_pend_r && !csum_load_s && !flush_s);
`endif
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= fifo_wdata_s;
    end
  end

  // FIFO pointers, count and in_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s < DEPTH_C);
    end
  end

  // FSM state and pin-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      data_r  <= 8'h00;
      tcnt_r  <= {TW{1'b0}};
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      req_r   <= req_next_s;
      data_r  <= data_next_s;
      tcnt_r  <= tcnt_next_s;
      err_r   <= err_next_s;
      busy_r  <= busy_next_s;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // Running frame checksum; the pending flag inserts the checksum byte ahead of the FIFO
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      csum_r      <= 8'h00;
      csum_pend_r <= 1'b0;
      cur_last_r  <= 1'b0;
    end else if (frame_done_s) begin
      csum_pend_r <= 1'b1;
    end else if (csum_load_s) begin
      csum_r      <= 8'h00;
      csum_pend_r <= 1'b0;
      cur_last_r  <= 1'b0;
    end else if (pop_s) begin
      csum_r      <= csum_step(csum_r, head_s[7:0]);
      cur_last_r  <= head_s[8];
    end
  end
`endif

endmodule

// File: tb/tb_tt_pin_frame_tx.sv
// Self-checking bench for tt_pin_frame_tx: randomized traffic against a byte-queue model,
// plus directed latency, back-pressure, timeout, ena and reset scenarios.
module tb_tt_pin_frame_tx;
  localparam int DEPTH = 4;
  localparam int TMO   = 255;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst, ena, in_last, in_valid, pin_ack;
  logic [7:0] in_data;
  logic       in_ready, pin_req, busy, timeout_err;
  logic [7:0] pin_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] m_xor;
  logic       rsp_on;
  int         rsp_delay;
  int         rwait;
  logic       req_prev;

  tt_pin_frame_tx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .pin_data(pin_data), .pin_req(pin_req),
    .pin_ack(pin_ack), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Project-side responder: raises ack rsp_delay cycles after req, drops it rsp_delay cycles after req falls
  initial begin
    pin_ack = 1'b0;
    rwait   = 0;
    forever begin
      @(posedge clk); #1;
      if (pin_req && !pin_ack && rsp_on) begin
        if (rwait >= rsp_delay) begin pin_ack = 1'b1; rwait = 0; end
        else rwait++;
      end else if (!pin_req && pin_ack) begin
        if (rwait >= rsp_delay) begin pin_ack = 1'b0; rwait = 0; end
        else rwait++;
      end else begin
        rwait = 0;
      end
    end
  end

  // Pin monitor: captures the byte presented at each req rising edge
  initial begin
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pin_req && !req_prev) got_q.push_back(pin_data);
      req_prev = pin_req;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: every accepted byte is delivered once, in order; with the checksum option the
  // XOR of the frame follows its last byte.
  task automatic model_accept(input logic [7:0] d, input logic l);
    exp_q.push_back(d);
`ifdef FRAME_CHECKSUM_EN
    m_xor = m_xor ^ d;
    if (l) begin
      exp_q.push_back(m_xor);
      m_xor = 8'h00;
    end
`else
    if (l) m_xor = 8'h00;
`endif
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; ena = 1'b1; rsp_on = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 200 && pin_ack; k++) begin @(posedge clk); #1; end
    exp_q.delete(); got_q.delete(); m_xor = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output int stalls);
    logic rdy;
    logic acc;
    acc = 1'b0; stalls = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    for (int k = 0; k < 3000 && !acc; k++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) acc = 1'b1; else stalls++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL send_accept: byte %02h not accepted, required accept", d); end
    else model_accept(d, l);
  endtask

  task automatic wait_req_high(input string nm, input int budget);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (pin_req !== 1'b1 && k < budget);
    n_checks++;
    if (pin_req !== 1'b1) begin n_fail++; $display("FAIL %s: pin_req=%b, required 1 within %0d cycles", nm, pin_req, budget); end
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while ((busy !== 1'b0 || pin_req !== 1'b0 || pin_ack !== 1'b0) && k < budget);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy=%b, required 0 within %0d cycles", nm, busy, budget); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks += 5;
    if (pin_data !== 8'h00) begin n_fail++; $display("FAIL reset_pin_data: got %02h, required 00", pin_data); end
    if (pin_req !== 1'b0) begin n_fail++; $display("FAIL reset_pin_req: got %b, required 0", pin_req); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b, required 0", timeout_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    rsp_on = 1'b1; rsp_delay = 3;
    in_data = 8'hA5; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(8'hA5, 1'b1);
    @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t: got %b, required 1", busy); end
    if (pin_data !== 8'h00) begin n_fail++; $display("FAIL single_data_t: got %02h, required 00", pin_data); end
    if (pin_req !== 1'b0) begin n_fail++; $display("FAIL single_req_t: got %b, required 0", pin_req); end
    @(negedge clk);
    n_checks += 2;
    if (pin_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_t1: got %02h, required a5", pin_data); end
    if (pin_req !== 1'b0) begin n_fail++; $display("FAIL single_req_t1: got %b, required 0", pin_req); end
    @(negedge clk);
    n_checks++;
    if (pin_req !== 1'b1) begin n_fail++; $display("FAIL single_req_t2: got %b, required 1", pin_req); end
    wait_done("single", 500);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d handshakes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d: got %02h, required %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_burst();
    int st, first_stall;
    do_reset();
    rsp_on = 1'b1; rsp_delay = 20; first_stall = -1;
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i), 1'b0, st);
      if (st > 0 && first_stall < 0) first_stall = i - 1;
    end
    n_checks++;
    if (first_stall !== DEPTH + 1) begin n_fail++; $display("FAIL burst_backpressure: first stall after %0d accepts, required %0d", first_stall, DEPTH + 1); end
    wait_done("burst", 3000);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL burst_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_byte%0d: got %02h, required %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int st, hi;
    do_reset();
    rsp_on = 1'b0;
    send_byte(8'h3C, 1'b0, st);
    send_byte(8'hC3, 1'b0, st);
    wait_req_high("timeout_req", 50);
    hi = 0;
    while (pin_req === 1'b1 && hi < 1000) begin hi++; @(negedge clk); end
    n_checks += 4;
    if (hi !== TMO) begin n_fail++; $display("FAIL timeout_len: req high %0d cycles, required %0d", hi, TMO); end
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b, required 1", timeout_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b, required 0", busy); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_in_ready: got %b, required 1", in_ready); end
    repeat (20) @(negedge clk);
    n_checks += 3;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b, required 1", timeout_err); end
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL timeout_flush: got %0d handshakes, required 1", got_q.size()); end
    if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL timeout_byte: got %02h, required %02h", got_q[0], exp_q[0]); end
    exp_q.delete(); got_q.delete(); m_xor = 8'h00;
  endtask

  task automatic test_ena_hold();
    int st, hi, k;
    do_reset();
    rsp_on = 1'b1; rsp_delay = 4;
    send_byte(8'h11, 1'b0, st);
    send_byte(8'h22, 1'b0, st);
    wait_req_high("ena_req", 50);
    ena = 1'b0;
    k = 0;
    while ((pin_req !== 1'b0 || pin_ack !== 1'b0) && k < 500) begin @(negedge clk); k++; end
    hi = 0;
    repeat (40) begin @(negedge clk); if (pin_req === 1'b1) hi++; end
    n_checks += 3;
    if (hi !== 0) begin n_fail++; $display("FAIL ena_hold_req: req high %0d cycles, required 0", hi); end
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL ena_hold_count: got %0d handshakes, required 1", got_q.size()); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ena_hold_busy: got %b, required 1", busy); end
    ena = 1'b1;
    wait_done("ena", 500);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ena_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ena_byte%0d: got %02h, required %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_checksum();
`ifdef FRAME_CHECKSUM_EN
    int st;
    do_reset();
    rsp_on = 1'b1; rsp_delay = 1;
    send_byte(8'h12, 1'b0, st);
    send_byte(8'h34, 1'b0, st);
    send_byte(8'h56, 1'b1, st);
    send_byte(8'h0F, 1'b1, st);
    wait_done("csum", 1000);
    n_checks += 2;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL csum_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() > 3 && got_q[3] !== 8'h70) begin n_fail++; $display("FAIL csum_value: got %02h, required 70", got_q[3]); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL csum_byte%0d: got %02h, required %02h", i, got_q[i], exp_q[i]); end
    end
`endif
  endtask

  task automatic test_random();
    int st, gap;
    do_reset();
    rsp_on = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rsp_delay = $urandom_range(0, 4);
      for (int i = 0; i < 10; i++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin @(posedge clk); #1; end
        send_byte(8'($urandom()), ($urandom_range(0, 3) == 0), st);
      end
    end
    wait_done("random", 2000);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_byte%0d: got %02h, required %02h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int st, hi;
    do_reset();
    rsp_on = 1'b1; rsp_delay = 10;
    send_byte(8'h5A, 1'b0, st);
    send_byte(8'h77, 1'b0, st);
    wait_req_high("rstmid_req", 50);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (pin_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b, required 0", pin_req); end
    if (pin_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %02h, required 00", pin_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
    hi = 0;
    repeat (30) begin @(negedge clk); if (pin_req === 1'b1) hi++; end
    n_checks++;
    if (hi !== 0) begin n_fail++; $display("FAIL rstmid_lost: req high %0d cycles after reset, required 0", hi); end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    rsp_on = 1'b0; rsp_delay = 0; m_xor = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_timeout();
    test_ena_hold();
    test_checksum();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
